// File: rtl/pcie_perst_seq_pkg.sv
// Shared types and default timing for the PERST#/flash reset sequencer.
package pcie_perst_seq_pkg;

  // Sequencer state; 3-bit encoding, unused codes recover to FLASH.
  typedef enum logic [2:0] {
    FLASH    = 3'd0,
    PERST    = 3'd1,
    WAIT_RDY = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } seq_state_e;

  localparam int PERST_CNT_W = 8;

  // Default timing at 100 MHz SYS_REFCLK.
  localparam int DEF_FLASH_DLY_CYC     = 1;
  localparam int DEF_PERST_HOLD_CYC    = 200;
  localparam int DEF_READY_STABLE_CYC  = 4;
  localparam int DEF_READY_TIMEOUT_CYC = 100000;
  localparam int DEF_MAX_RETRY         = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pcie_perst_sequencer_if.sv
// Reset-sequencing bus between the sequencer (master) and the DUT/bench side (slave).
interface pcie_perst_sequencer_if;
  import pcie_perst_seq_pkg::*;

  logic                   hot_reset_req;
  logic                   dut_ready;
  logic                   pcie_reset_n;
  logic                   flash_reset;
  logic                   seq_busy;
  logic                   seq_done;
  logic                   timeout_err;
  logic [PERST_CNT_W-1:0] perst_count;

  modport master (
    input  hot_reset_req, dut_ready,
    output pcie_reset_n, flash_reset, seq_busy, seq_done, timeout_err, perst_count
  );

  modport slave (
    output hot_reset_req, dut_ready,
    input  pcie_reset_n, flash_reset, seq_busy, seq_done, timeout_err, perst_count
  );

endinterface

// File: rtl/pcie_perst_stable_det.sv
// Consecutive-high detector: stable rises once din has been 1 for STABLE_CYC
// back-to-back cycles; any 0 or clr restarts the run.
module pcie_perst_stable_det #(
  parameter int STABLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic stable
);

  localparam int W = $clog2(STABLE_CYC + 1);

  logic [W-1:0] run_q, run_d;

  // Run length: restart on clr or a low sample, saturate at the target.
  always_comb begin
    run_d = run_q;
    if (clr || !din) begin
      run_d = '0;
    end else if (run_q != W'(STABLE_CYC)) begin
      run_d = run_q + W'(1);
    end
  end

  // Run-length register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign stable = (run_q == W'(STABLE_CYC));

endmodule

// File: rtl/pcie_perst_sequencer.sv
// PCIe PERST#/flash reset sequencer: releases flash_reset, pulses PERST#,
// qualifies dut_ready, flags link-up timeouts and services hot-reset requests.
// Optional build macro PCIE_PERST_AUTO_RETRY_EN: on a link-up timeout, re-pulse
// PERST# up to MAX_RETRY times before raising timeout_err.
module pcie_perst_sequencer
  import pcie_perst_seq_pkg::*;
#(
  parameter int FLASH_DLY_CYC     = DEF_FLASH_DLY_CYC,
  parameter int PERST_HOLD_CYC    = DEF_PERST_HOLD_CYC,
  parameter int READY_STABLE_CYC  = DEF_READY_STABLE_CYC,
  parameter int READY_TIMEOUT_CYC = DEF_READY_TIMEOUT_CYC,
  parameter int MAX_RETRY         = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_perst_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(max3(FLASH_DLY_CYC, PERST_HOLD_CYC, READY_TIMEOUT_CYC)) + 1;

  if (FLASH_DLY_CYC < 1)     begin : g_bad_flash   $error("FLASH_DLY_CYC must be >= 1");     end
  if (PERST_HOLD_CYC < 1)    begin : g_bad_perst   $error("PERST_HOLD_CYC must be >= 1");    end
  if (READY_STABLE_CYC < 1)  begin : g_bad_stable  $error("READY_STABLE_CYC must be >= 1");  end
  if (READY_TIMEOUT_CYC < 1) begin : g_bad_timeout $error("READY_TIMEOUT_CYC must be >= 1"); end
  if (MAX_RETRY < 1)         begin : g_bad_retry   $error("MAX_RETRY must be >= 1");         end

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pcie_reset_n_q, pcie_reset_n_d;
  logic                   flash_reset_q, flash_reset_d;
  logic                   seq_busy_q, seq_busy_d;
  logic                   seq_done_q, seq_done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [PERST_CNT_W-1:0] perst_count_q, perst_count_d;
  logic                   ready_ok;
  logic                   det_clr;
`ifdef PCIE_PERST_AUTO_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
  logic [RETRY_W-1:0]     retry_q, retry_d;
`endif

  // The stable run only counts while waiting for the link.
  assign det_clr = (state_q != WAIT_RDY);

  pcie_perst_stable_det #(
    .STABLE_CYC (READY_STABLE_CYC)
  ) u_stable_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (det_clr),
    .din    (bus.dut_ready),
    .stable (ready_ok)
  );

  // State, counter and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FLASH;
      cnt_q          <= '0;
      pcie_reset_n_q <= 1'b0;
      flash_reset_q  <= 1'b0;
      seq_busy_q     <= 1'b1;
      seq_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
      perst_count_q  <= '0;
`ifdef PCIE_PERST_AUTO_RETRY_EN
      retry_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pcie_reset_n_q <= pcie_reset_n_d;
      flash_reset_q  <= flash_reset_d;
      seq_busy_q     <= seq_busy_d;
      seq_done_q     <= seq_done_d;
      timeout_err_q  <= timeout_err_d;
      perst_count_q  <= perst_count_d;
`ifdef PCIE_PERST_AUTO_RETRY_EN
      retry_q        <= retry_d;
`endif
    end
  end

  // Next state; in WAIT_RDY hot reset beats qualification, which beats timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PCIE_PERST_AUTO_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      FLASH: begin
        if (cnt_q == CNT_W'(FLASH_DLY_CYC - 1)) begin
          state_d = PERST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PERST: begin
        if (cnt_q == CNT_W'(PERST_HOLD_CYC - 1)) begin
          state_d = WAIT_RDY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RDY: begin
        if (bus.hot_reset_req) begin
          state_d = PERST;
          cnt_d   = '0;
`ifdef PCIE_PERST_AUTO_RETRY_EN
          retry_d = '0;
`endif
        end else if (ready_ok) begin
          state_d = DONE;
          cnt_d   = '0;
`ifdef PCIE_PERST_AUTO_RETRY_EN
          retry_d = '0;
`endif
        end else if (cnt_q == CNT_W'(READY_TIMEOUT_CYC - 1)) begin
          cnt_d = '0;
`ifdef PCIE_PERST_AUTO_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = PERST;
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            state_d = ERR;
          end
`else
          state_d = ERR;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE, ERR: begin
        if (bus.hot_reset_req) begin
          state_d = PERST;
          cnt_d   = '0;
`ifdef PCIE_PERST_AUTO_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      default: begin
        state_d = FLASH;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the state being entered; every PERST entry is one pulse.
  always_comb begin
    pcie_reset_n_d = (state_d == WAIT_RDY) || (state_d == DONE) || (state_d == ERR);
    flash_reset_d  = (state_d != FLASH);
    seq_busy_d     = (state_d == FLASH) || (state_d == PERST) || (state_d == WAIT_RDY);
    seq_done_d     = (state_d == DONE);
    timeout_err_d  = timeout_err_q || (state_d == ERR);
    perst_count_d  = perst_count_q;
    if ((state_d == PERST) && (state_q != PERST) && (perst_count_q != '1)) begin
      perst_count_d = perst_count_q + PERST_CNT_W'(1);
    end
  end

  assign bus.pcie_reset_n = pcie_reset_n_q;
  assign bus.flash_reset  = flash_reset_q;
  assign bus.seq_busy     = seq_busy_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.perst_count  = perst_count_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Bench for pcie_perst_sequencer: output edges are logged as timestamped events
// and matched in order against expectations derived from the sequencing rules.
module tb_pcie_perst_sequencer;
  import pcie_perst_seq_pkg::*;

  localparam int F  = 1;
  localparam int P  = 200;
  localparam int S  = 4;
  localparam int T  = 50;
  localparam int MR = 2;

  localparam int EV_FLASH_RISE = 0;
  localparam int EV_PERST_FALL = 1;
  localparam int EV_PERST_RISE = 2;
  localparam int EV_DONE_RISE  = 3;
  localparam int EV_DONE_FALL  = 4;
  localparam int EV_TO_RISE    = 5;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic prev_fr = 1'b0, prev_prn = 1'b0, prev_done = 1'b0, prev_to = 1'b0;

  pcie_perst_sequencer_if bus();

  pcie_perst_sequencer #(
    .FLASH_DLY_CYC     (F),
    .PERST_HOLD_CYC    (P),
    .READY_STABLE_CYC  (S),
    .READY_TIMEOUT_CYC (T),
    .MAX_RETRY         (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cyc equals the spec cycle number of the value seen at the following negedge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic ev_t mk_ev(input int k, input int c, input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    return e;
  endfunction

  function automatic string ev_name(input int k);
    case (k)
      EV_FLASH_RISE: return "flash_rise";
      EV_PERST_FALL: return "perst_fall";
      EV_PERST_RISE: return "perst_rise";
      EV_DONE_RISE:  return "done_rise";
      EV_DONE_FALL:  return "done_fall";
      EV_TO_RISE:    return "timeout_rise";
      default:       return "none";
    endcase
  endfunction

  // Output edge monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (!prev_fr && bus.flash_reset === 1'b1)
        obs_q.push_back(mk_ev(EV_FLASH_RISE, cyc, int'(bus.perst_count)));
      if (prev_prn && bus.pcie_reset_n === 1'b0)
        obs_q.push_back(mk_ev(EV_PERST_FALL, cyc, int'(bus.perst_count)));
      if (!prev_prn && bus.pcie_reset_n === 1'b1)
        obs_q.push_back(mk_ev(EV_PERST_RISE, cyc, int'(bus.perst_count)));
      if (!prev_done && bus.seq_done === 1'b1)
        obs_q.push_back(mk_ev(EV_DONE_RISE, cyc, int'(bus.perst_count)));
      if (prev_done && bus.seq_done === 1'b0)
        obs_q.push_back(mk_ev(EV_DONE_FALL, cyc, int'(bus.perst_count)));
      if (!prev_to && bus.timeout_err === 1'b1)
        obs_q.push_back(mk_ev(EV_TO_RISE, cyc, int'(bus.perst_count)));
    end
    prev_fr   = bus.flash_reset;
    prev_prn  = bus.pcie_reset_n;
    prev_done = bus.seq_done;
    prev_to   = bus.timeout_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic get_obs(output ev_t o, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    o  = mk_ev(-1, -1, -1);
    while (obs_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() != 0) begin
      o  = obs_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_reset(input logic ready);
    @(negedge clk);
    rst = 1'b1;
    bus.hot_reset_req = 1'b0;
    bus.dut_ready = ready;
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.hot_reset_req = 1'b0;
    bus.dut_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.pcie_reset_n !== 1'b0) begin errors++; $display("FAIL reset_pcie_reset_n: got %b want 0", bus.pcie_reset_n); end
    if (bus.flash_reset !== 1'b0) begin errors++; $display("FAIL reset_flash_reset: got %b want 0", bus.flash_reset); end
    if (bus.seq_busy !== 1'b1) begin errors++; $display("FAIL reset_seq_busy: got %b want 1", bus.seq_busy); end
    if (bus.seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", bus.seq_done); end
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    if (bus.perst_count !== 8'd0) begin errors++; $display("FAIL reset_perst_count: got %0d want 0", bus.perst_count); end
  endtask

  task automatic test_power_up();
    ev_t e, o;
    bit ok;
    apply_reset(1'b1);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + S + 1, 1));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL power_up: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL power_up: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
    checks++;
    if (bus.seq_busy !== 1'b0) begin errors++; $display("FAIL power_up_busy: got %b want 0", bus.seq_busy); end
  endtask

  task automatic test_ready_glitch();
    ev_t e, o;
    bit ok;
    apply_reset(1'b0);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + 4 + S + 1, 1));
    wait_cyc(F + P);
    bus.dut_ready = 1'b1;
    wait_cyc(F + P + 3);
    bus.dut_ready = 1'b0;
    wait_cyc(F + P + 4);
    bus.dut_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL ready_glitch: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL ready_glitch: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    bit ok;
    int rc, npulse, c0;
    apply_reset(1'b0);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    rc = F + P;
`ifdef PCIE_PERST_AUTO_RETRY_EN
    for (int r = 1; r <= MR; r++) begin
      exp_q.push_back(mk_ev(EV_PERST_FALL, rc + T, r + 1));
      rc = rc + T + P;
      exp_q.push_back(mk_ev(EV_PERST_RISE, rc, r + 1));
    end
    npulse = MR + 1;
`else
    npulse = 1;
`endif
    exp_q.push_back(mk_ev(EV_TO_RISE, rc + T, npulse));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL timeout: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL timeout: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
    repeat (10) @(negedge clk);
    checks += 4;
    if (bus.pcie_reset_n !== 1'b1) begin errors++; $display("FAIL err_pcie_reset_n: got %b want 1", bus.pcie_reset_n); end
    if (bus.seq_busy !== 1'b0 || bus.seq_done !== 1'b0) begin
      errors++; $display("FAIL err_busy_done: got busy=%b done=%b want 0/0", bus.seq_busy, bus.seq_done);
    end
    if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL err_timeout_err: got %b want 1", bus.timeout_err); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL err_quiet: got %0d extra events want 0", obs_q.size()); end
    // Hot reset out of ERR: new pulse, timeout_err stays set.
    obs_q.delete();
    c0 = cyc;
    bus.dut_ready = 1'b1;
    bus.hot_reset_req = 1'b1;
    @(negedge clk);
    bus.hot_reset_req = 1'b0;
    exp_q.push_back(mk_ev(EV_PERST_FALL, c0 + 1, npulse + 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, c0 + 1 + P, npulse + 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, c0 + 1 + P + S + 1, npulse + 1));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL err_hot: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL err_hot: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL err_hot_sticky: got %b want 1", bus.timeout_err); end
  endtask

  task automatic test_hot_done();
    ev_t e, o;
    bit ok;
    apply_reset(1'b1);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + S + 1, 1));
    exp_q.push_back(mk_ev(EV_PERST_FALL, 211, 2));
    exp_q.push_back(mk_ev(EV_DONE_FALL, 211, 2));
    exp_q.push_back(mk_ev(EV_PERST_RISE, 211 + P, 2));
    exp_q.push_back(mk_ev(EV_DONE_RISE, 211 + P + S + 1, 2));
    wait_cyc(207);
    bus.dut_ready = 1'b0;
    wait_cyc(210);
    bus.dut_ready = 1'b1;
    bus.hot_reset_req = 1'b1;
    @(negedge clk);
    bus.hot_reset_req = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL hot_done: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL hot_done: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
    checks++;
    if (bus.flash_reset !== 1'b1) begin errors++; $display("FAIL hot_done_flash: got %b want 1", bus.flash_reset); end
  endtask

  task automatic test_hot_qualify();
    ev_t e, o;
    bit ok;
    apply_reset(1'b1);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_PERST_FALL, F + P + S + 1, 2));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P + S + 1 + P, 2));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + S + 1 + P + S + 1, 2));
    wait_cyc(F + P + S);
    bus.hot_reset_req = 1'b1;
    @(negedge clk);
    bus.hot_reset_req = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL hot_qualify: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL hot_qualify: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
  endtask

  task automatic test_hot_ignored();
    ev_t e, o;
    bit ok;
    apply_reset(1'b1);
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + S + 1, 1));
    bus.hot_reset_req = 1'b1;
    @(negedge clk);
    bus.hot_reset_req = 1'b0;
    wait_cyc(100);
    bus.hot_reset_req = 1'b1;
    @(negedge clk);
    bus.hot_reset_req = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL hot_ignored: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL hot_ignored: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
  endtask

  task automatic test_rst_mid_perst();
    ev_t e, o;
    bit ok;
    apply_reset(1'b1);
    wait_cyc(100);
    checks++;
    if (bus.pcie_reset_n !== 1'b0 || bus.flash_reset !== 1'b1) begin
      errors++; $display("FAIL mid_perst_pre: got prn=%b fr=%b want 0/1", bus.pcie_reset_n, bus.flash_reset);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pcie_reset_n !== 1'b0 || bus.flash_reset !== 1'b0 || bus.seq_busy !== 1'b1 ||
        bus.seq_done !== 1'b0 || bus.timeout_err !== 1'b0 || bus.perst_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_perst_rst: got prn=%b fr=%b busy=%b done=%b to=%b cnt=%0d want 0 0 1 0 0 0",
               bus.pcie_reset_n, bus.flash_reset, bus.seq_busy, bus.seq_done, bus.timeout_err, bus.perst_count);
    end
    @(negedge clk);
    obs_q.delete();
    rst = 1'b0;
    exp_q.push_back(mk_ev(EV_FLASH_RISE, F, 1));
    exp_q.push_back(mk_ev(EV_PERST_RISE, F + P, 1));
    exp_q.push_back(mk_ev(EV_DONE_RISE, F + P + S + 1, 1));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL mid_perst_restart: got no event, want %s@%0d", ev_name(e.kind), e.cyc); break;
      end else if (o.kind !== e.kind || o.cyc !== e.cyc || o.cnt !== e.cnt) begin
        errors++; $display("FAIL mid_perst_restart: got %s@%0d cnt=%0d want %s@%0d cnt=%0d", ev_name(o.kind), o.cyc, o.cnt, ev_name(e.kind), e.cyc, e.cnt);
      end
    end
  endtask

  task automatic test_count_saturate();
    ev_t e, o;
    bit ok;
    int want;
    apply_reset(1'b0);
    get_obs(o, ok);
    checks++;
    if (!ok || o.kind !== EV_FLASH_RISE) begin
      errors++; $display("FAIL saturate_start: got %s want flash_rise", ev_name(o.kind));
    end else begin
      for (int k = 1; k <= 255; k++) begin
        exp_q.push_back(mk_ev(EV_PERST_RISE, -1, k));
        get_obs(o, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o.kind !== e.kind || o.cnt !== e.cnt) begin
          errors++; $display("FAIL saturate_rise %0d: got %s cnt=%0d want %s cnt=%0d", k, ev_name(o.kind), o.cnt, ev_name(e.kind), e.cnt);
          break;
        end
        bus.hot_reset_req = 1'b1;
        @(negedge clk);
        bus.hot_reset_req = 1'b0;
        want = (k + 1 > 255) ? 255 : k + 1;
        exp_q.push_back(mk_ev(EV_PERST_FALL, -1, want));
        get_obs(o, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o.kind !== e.kind || o.cnt !== e.cnt) begin
          errors++; $display("FAIL saturate_fall %0d: got %s cnt=%0d want %s cnt=%0d", k, ev_name(o.kind), o.cnt, ev_name(e.kind), e.cnt);
          break;
        end
      end
    end
    checks++;
    if (bus.perst_count !== 8'd255) begin errors++; $display("FAIL saturate_final: got %0d want 255", bus.perst_count); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ready_glitch();
    test_timeout();
    test_hot_done();
    test_hot_qualify();
    test_hot_ignored();
    test_rst_mid_perst();
    test_count_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
